instr_fetch: RTL and testbench

Instruction fetch and issue-buffer stage directly upstream of the dual-issue pipes. Keeps the fetch PC and reads aligned instruction pairs from a synchronous instruction memory. Buffers the pairs in a small FIFO and presents one pair per cycle as `instr_even`/`instr_odd` with its `pc`. Redirects on `branch_taken`/`pc_wb` coming back from the odd pipe, flushing all buffered and in-flight pairs.

---
 rtl/instr_fetch.sv | 131 +++++++++++++
 tb/tb_instr_fetch.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: fetch PC, synchronous instruction-pair reads, issue FIFO and
// branch redirect for the dual-issue pipes.
//
// Handshake: imem_rd_en/imem_addr form a request with no back-pressure. The
// memory returns the pair on imem_rdata exactly one cycle later. A request is
// only made when the FIFO has room for it, counting the one already in flight.
// On the issue side, issue_valid marks a real pair. The pair is consumed
// (popped) in any cycle where issue_valid=1 and stall=0.
module instr_fetch #(
  parameter int PC_W  = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] pc_wb,
  output logic            imem_rd_en,
  output logic [PC_W-2:0] imem_addr,
  input  logic [0:63]     imem_rdata,
  output logic            issue_valid,
  output logic [0:31]     instr_even,
  output logic [0:31]     instr_odd,
  output logic [PC_W-1:0] pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0]  DEPTH_V = (CNT_W + 1)'(DEPTH);
  localparam logic [PC_W-1:0] PAIR_STEP = PC_W'(2);

  // Fetch side state
  logic [PC_W-1:0] fetch_pc;
  logic            odd_pend;   // next request is the first after an odd redirect
  logic            req_q;      // a response arrives this cycle
  logic [PC_W-1:0] req_pc;     // even-aligned pc of the in-flight pair
  logic            req_odd;    // in-flight pair entered at its odd word

  // Issue FIFO
  logic [0:31]     fifo_even [DEPTH];
  logic [0:31]     fifo_odd  [DEPTH];
  logic [PC_W-1:0] fifo_pc   [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  // Derived control
  logic [CNT_W:0]  occupancy;
  logic            room;
  logic            nonempty;
  logic            capture;
  logic            pop;
  logic [PC_W-1:0] aligned_pc;

  // Request/issue decisions from current state and the redirect strobe
  always_comb begin
    occupancy   = {1'b0, count} + {{CNT_W{1'b0}}, req_q};
    room        = occupancy < DEPTH_V;
    nonempty    = count != '0;
    aligned_pc  = {fetch_pc[PC_W-1:1], 1'b0};
    imem_rd_en  = reset & ~branch_taken & room;
    imem_addr   = reset ? fetch_pc[PC_W-1:1] : '0;
    issue_valid = reset & ~branch_taken & nonempty;
    capture     = req_q & ~branch_taken;
    pop         = issue_valid & ~stall;
  end

  // Presented pair: the FIFO head when valid, otherwise a nop
  always_comb begin
    instr_even = '0;
    instr_odd  = '0;
    pc         = '0;
    if (issue_valid) begin
      instr_even = fifo_even[rd_ptr];
      instr_odd  = fifo_odd[rd_ptr];
    end
    if (reset && nonempty) begin
      pc = fifo_pc[rd_ptr];
    end
  end

  // Fetch PC, in-flight tracking, pointers and occupancy; redirect wins
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= '0;
      odd_pend <= 1'b0;
      req_q    <= 1'b0;
      req_pc   <= '0;
      req_odd  <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (branch_taken) begin
      fetch_pc <= pc_wb;
      odd_pend <= pc_wb[0];
      req_q    <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      req_q <= imem_rd_en;
      if (imem_rd_en) begin
        req_pc   <= aligned_pc;
        req_odd  <= odd_pend;
        odd_pend <= 1'b0;
        fetch_pc <= aligned_pc + PAIR_STEP;
      end
      if (capture) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({capture, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write; the even word of an odd-entry pair becomes a nop
  always_ff @(posedge clk) begin
    if (reset && capture) begin
      fifo_even[wr_ptr] <= req_odd ? 32'h0 : imem_rdata[0:31];
      fifo_odd[wr_ptr]  <= imem_rdata[32:63];
      fifo_pc[wr_ptr]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus random stall/branch/reset traffic,
// checked every cycle against a queue-based reference model.
module tb_instr_fetch;

  localparam int PC_W  = 8;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            stall;
  logic            branch_taken;
  logic [PC_W-1:0] pc_wb;
  logic            imem_rd_en;
  logic [PC_W-2:0] imem_addr;
  logic [0:63]     imem_rdata;
  logic            issue_valid;
  logic [0:31]     instr_even;
  logic [0:31]     instr_odd;
  logic [PC_W-1:0] pc;

  instr_fetch #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .pc_wb        (pc_wb),
    .imem_rd_en   (imem_rd_en),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .issue_valid  (issue_valid),
    .instr_even   (instr_even),
    .instr_odd    (instr_odd),
    .pc           (pc)
  );

  // ---------------- instruction memory ----------------
  // Word w holds 0x1000_0000+w when even, 0x2000_0000+w when odd.
  function automatic logic [31:0] word_at(logic [PC_W-1:0] w);
    if (w[0]) return 32'h2000_0000 + 32'(w);
    else      return 32'h1000_0000 + 32'(w);
  endfunction

  initial imem_rdata = '0;
  always @(posedge clk) begin
    if (imem_rd_en) begin
      imem_rdata <= {word_at({imem_addr, 1'b0}), word_at({imem_addr, 1'b1})};
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_errors = 0;

  logic [PC_W-1:0] exp_q[$];       // pc of each buffered pair, oldest first
  logic [31:0]     exp_even_q[$];
  logic [31:0]     exp_odd_q[$];
  bit              m_inflight;
  logic [PC_W-1:0] m_ipc;
  bit              m_iodd;
  logic [PC_W-1:0] m_fpc;
  bit              m_podd;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_even_q.delete();
    exp_odd_q.delete();
    m_inflight = 0;
  endtask

  // Compare all outputs with what the model predicts for the current inputs
  task automatic compare_model();
    bit room;
    bit v;
    room = (exp_q.size() + int'(m_inflight)) < DEPTH;
    v    = reset && !branch_taken && exp_q.size() > 0;
    check("rd_en", imem_rd_en, reset && !branch_taken && room);
    check("addr", imem_addr, reset ? m_fpc[PC_W-1:1] : '0);
    check("valid", issue_valid, v);
    check("even", instr_even, v ? exp_even_q[0] : 32'h0);
    check("odd", instr_odd, v ? exp_odd_q[0] : 32'h0);
    check("pc", pc, (reset && exp_q.size() > 0) ? exp_q[0] : '0);
  endtask

  // Advance the model across one rising edge
  task automatic model_edge();
    int  sz;
    bit  req;
    if (!reset) begin
      model_clear();
      m_fpc  = '0;
      m_podd = 0;
    end else if (branch_taken) begin
      model_clear();
      m_fpc  = pc_wb;
      m_podd = pc_wb[0];
    end else begin
      sz  = exp_q.size();
      req = (sz + int'(m_inflight)) < DEPTH;
      if (sz > 0 && !stall) begin
        void'(exp_q.pop_front());
        void'(exp_even_q.pop_front());
        void'(exp_odd_q.pop_front());
      end
      if (m_inflight) begin
        exp_q.push_back(m_ipc);
        exp_even_q.push_back(m_iodd ? 32'h0 : word_at(m_ipc));
        exp_odd_q.push_back(word_at(m_ipc + PC_W'(1)));
      end
      if (req) begin
        m_ipc  = {m_fpc[PC_W-1:1], 1'b0};
        m_iodd = m_podd;
        m_podd = 0;
        m_fpc  = m_ipc + PC_W'(2);
      end
      m_inflight = req;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(bit st, bit br, logic [PC_W-1:0] wb, bit rst);
    stall        = st;
    branch_taken = br;
    pc_wb        = wb;
    reset        = rst;
    #1;
    compare_model();
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, '0, 1);
      step();
    end
  endtask

  // ---------------- stimulus ----------------
  logic [PC_W-1:0] held_pc;
  logic [PC_W-1:0] wrap_exp [4];

  initial begin
    reset = 0; stall = 0; branch_taken = 0; pc_wb = '0;
    m_fpc = '0; m_podd = 0; m_ipc = '0; m_iodd = 0; m_inflight = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset values
    drive(0, 0, '0, 0);
    check("rst_rd_en", imem_rd_en, 0);
    check("rst_pc", pc, 0);
    step();

    // Start-up latency and streaming
    drive(0, 0, '0, 1);
    check("c1_rd_en", imem_rd_en, 1);
    check("c1_addr", imem_addr, 0);
    step();
    run(1);
    drive(0, 0, '0, 1);
    check("c3_valid", issue_valid, 1);
    check("c3_pc", pc, 0);
    check("c3_even", instr_even, 32'h1000_0000);
    check("c3_odd", instr_odd, 32'h2000_0001);
    step();
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, '0, 1);
      check("stream_pc", pc, 64'(2 * i));
      step();
    end

    // Stall for 10 cycles: head holds, requests stop once full
    drive(1, 0, '0, 1);
    held_pc = exp_q[0];
    step();
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, '0, 1);
      check("stall_pc", pc, held_pc);
      step();
    end
    drive(1, 0, '0, 1);
    check("full_rd_en", imem_rd_en, 0);
    check("full_valid", issue_valid, 1);

    // Redirect to 40 while full
    drive(0, 1, PC_W'(40), 1);
    check("br_valid", issue_valid, 0);
    check("br_even", instr_even, 0);
    check("br_rd_en", imem_rd_en, 0);
    step();
    drive(0, 0, '0, 1);
    check("br_addr", imem_addr, 20);
    check("br_req", imem_rd_en, 1);
    step();
    run(1);
    drive(0, 0, '0, 1);
    check("br_t3_valid", issue_valid, 1);
    check("br_t3_pc", pc, 40);
    step();

    // Redirect to an odd word
    drive(0, 1, PC_W'(41), 1);
    step();
    run(2);
    drive(0, 0, '0, 1);
    check("odd_pc", pc, 40);
    check("odd_even", instr_even, 0);
    check("odd_odd", instr_odd, 32'h2000_0029);
    step();

    // PC wrap past 254
    wrap_exp[0] = PC_W'(252); wrap_exp[1] = PC_W'(254);
    wrap_exp[2] = PC_W'(0);   wrap_exp[3] = PC_W'(2);
    drive(0, 1, PC_W'(252), 1);
    step();
    run(2);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, '0, 1);
      check("wrap_pc", pc, wrap_exp[i]);
      step();
    end

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 9) < 4,
            $urandom_range(0, 19) == 0,
            PC_W'($urandom_range(0, 255)),
            $urandom_range(0, 49) != 0);
      step();
    end

    // Branch together with stall, then reset with a response in flight
    run(6);
    drive(1, 1, PC_W'(100), 1);
    check("bs_valid", issue_valid, 0);
    step();
    drive(1, 0, '0, 1);
    check("bs_addr", imem_addr, 50);
    check("bs_req", imem_rd_en, 1);
    step();
    drive(1, 0, '0, 0);
    check("mr_rd_en", imem_rd_en, 0);
    check("mr_addr", imem_addr, 0);
    check("mr_valid", issue_valid, 0);
    check("mr_pc", pc, 0);
    step();
    drive(0, 0, '0, 1);
    check("ar_valid", issue_valid, 0);
    check("ar_pc", pc, 0);
    check("ar_addr", imem_addr, 0);
    check("ar_req", imem_rd_en, 1);
    step();
    run(1);
    drive(0, 0, '0, 1);
    check("ar_c3_valid", issue_valid, 1);
    check("ar_c3_pc", pc, 0);
    check("ar_c3_even", instr_even, 32'h1000_0000);
    step();
    run(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
